// File: rtl/mult_row_sequencer_if.sv
// Handshake bundle between the row sequencer, the classifier FSM and the row multiplier.
// The sequencer uses the master modport; the environment side uses the slave modport.
interface mult_row_sequencer_if;
  logic        start;
  logic        abort;
  logic        done_row;
  logic [15:0] row_result;
  logic        row_overflow;
  logic [3:0]  row_select;
  logic        begin_mult;
  logic        busy;
  logic        res_valid;
  logic [3:0]  res_row;
  logic [15:0] res_data;
  logic        res_ovf;
  logic        done;
  logic [3:0]  class_out;
  logic [15:0] max_value;
  logic        ovf_any;

  modport master (
    input  start, abort, done_row, row_result, row_overflow,
    output row_select, begin_mult, busy, res_valid, res_row, res_data, res_ovf,
           done, class_out, max_value, ovf_any
  );

  modport slave (
    output start, abort, done_row, row_result, row_overflow,
    input  row_select, begin_mult, busy, res_valid, res_row, res_data, res_ovf,
           done, class_out, max_value, ovf_any
  );
endinterface

// File: rtl/mult_row_sequencer.sv
// Launches one multiplier row per output neuron, streams the row results and tracks the argmax.
// Define MULT_SAT_EN to capture overflowed rows as 16'hFFFF instead of the wrapped value.
//
// state   | meaning
// IDLE    | waiting for start; held results visible
// LAUNCH  | begin_mult pulse for the current row
// WAIT    | row_select held, waiting for done_row
// CAPTURE | res_valid pulse, argmax/ovf_any update
// FINISH  | done pulse, then back to IDLE
module mult_row_sequencer #(
  parameter int NUM_ROWS = 10
) (
  input  logic                  clk,
  input  logic                  n_rst,
  mult_row_sequencer_if.master  bus
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, FINISH} state_t;

  localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);

  state_t      state;
  logic [15:0] cap_value;

`ifdef MULT_SAT_EN
  assign cap_value = bus.row_overflow ? 16'hFFFF : bus.row_result;
`else
  assign cap_value = bus.row_result;
`endif

  // row_select doubles as the row counter; it only moves on CAPTURE -> LAUNCH
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      bus.row_select <= 4'd0;
      bus.begin_mult <= 1'b0;
      bus.busy       <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.res_row    <= 4'd0;
      bus.res_data   <= 16'd0;
      bus.res_ovf    <= 1'b0;
      bus.done       <= 1'b0;
      bus.class_out  <= 4'd0;
      bus.max_value  <= 16'd0;
      bus.ovf_any    <= 1'b0;
    end else begin
      bus.begin_mult <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.done       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.row_select <= 4'd0;
            bus.class_out  <= 4'd0;
            bus.max_value  <= 16'd0;
            bus.ovf_any    <= 1'b0;
            bus.begin_mult <= 1'b1;
            bus.busy       <= 1'b1;
            state          <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (bus.done_row) begin
            bus.res_data  <= cap_value;
            bus.res_ovf   <= bus.row_overflow;
            bus.res_row   <= bus.row_select;
            bus.res_valid <= 1'b1;
            state         <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            // strict compare keeps the lower index on ties
            if (bus.res_row == 4'd0 || bus.res_data > bus.max_value) begin
              bus.max_value <= bus.res_data;
              bus.class_out <= bus.res_row;
            end
            bus.ovf_any <= bus.ovf_any | bus.res_ovf;
            if (bus.row_select == LAST_ROW) begin
              bus.done <= 1'b1;
              state    <= FINISH;
            end else begin
              bus.row_select <= bus.row_select + 4'd1;
              bus.begin_mult <= 1'b1;
              state          <= LAUNCH;
            end
          end
        end
        FINISH: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_row_sequencer.sv
// Directed bench for mult_row_sequencer: full passes, overflow handling, abort, stray inputs, async reset.
module tb_mult_row_sequencer;
  localparam int NUM_ROWS = 10;

  logic clk = 1'b0;
  logic n_rst;
  int   n_cmp = 0;
  int   n_err = 0;

  mult_row_sequencer_if bus();

  mult_row_sequencer #(.NUM_ROWS(NUM_ROWS)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] vals [NUM_ROWS];
  logic        ovfs [NUM_ROWS];

  // pulse counters and launch-window checks, sampled on the falling edge
  logic       mon_clr;
  int         bm_cnt, rv_cnt, done_cnt, wide_err, sel_err;
  logic       bm_prev, in_win;
  logic [3:0] sel_hold;

  always @(negedge clk) begin
    if (mon_clr) begin
      bm_cnt   <= 0;
      rv_cnt   <= 0;
      done_cnt <= 0;
      wide_err <= 0;
      sel_err  <= 0;
      bm_prev  <= 1'b0;
      in_win   <= 1'b0;
      sel_hold <= 4'd0;
    end else begin
      bm_prev <= bus.begin_mult;
      if (bus.begin_mult) begin
        bm_cnt   <= bm_cnt + 1;
        sel_hold <= bus.row_select;
        in_win   <= 1'b1;
        if (bm_prev) wide_err <= wide_err + 1;
      end else if (in_win) begin
        if (bus.row_select !== sel_hold) sel_err <= sel_err + 1;
        if (bus.res_valid) in_win <= 1'b0;
      end
      if (bus.res_valid) rv_cnt <= rv_cnt + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input int r);
`ifdef MULT_SAT_EN
    return ovfs[r] ? 16'hFFFF : vals[r];
`else
    return vals[r];
`endif
  endfunction

  // Acts as the multiplier for nrows rows; expects to be entered with a launch pending or present.
  task automatic run_pass(input int lat, input int nrows, input bit stray);
    int guard;
    for (int r = 0; r < nrows; r++) begin
      guard = 0;
      while (bus.begin_mult !== 1'b1 && guard < 50) begin
        step();
        guard++;
      end
      chk("launch_seen", 32'(guard < 50), 32'd1);
      for (int i = 0; i < lat; i++) begin
        if (stray && r == 2 && i == 10) bus.start = 1'b1;
        step();
        bus.start = 1'b0;
      end
      bus.done_row     = 1'b1;
      bus.row_result   = vals[r];
      bus.row_overflow = ovfs[r];
      step();
      bus.done_row     = 1'b0;
      bus.row_result   = 16'h0;
      bus.row_overflow = 1'b0;
      chk("res_valid", bus.res_valid, 1);
      chk("res_row", bus.res_row, r);
      chk("res_data", bus.res_data, exp_data(r));
      chk("res_ovf", bus.res_ovf, ovfs[r]);
      step();
      if (r == NUM_ROWS - 1) chk("done", bus.done, 1);
      else                   chk("next_launch", bus.begin_mult, 1);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_to_launch", bus.begin_mult, 1);
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.done_row     = 1'b0;
    bus.row_result   = 16'h0;
    bus.row_overflow = 1'b0;
    n_rst            = 1'b0;
    mon_clr          = 1'b1;
    repeat (3) step();

    chk("rst_row_select", bus.row_select, 0);
    chk("rst_begin_mult", bus.begin_mult, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_class_out", bus.class_out, 0);
    chk("rst_max_value", bus.max_value, 0);
    chk("rst_ovf_any", bus.ovf_any, 0);

    n_rst   = 1'b1;
    mon_clr = 1'b0;
    step();

    // stray done_row while idle
    bus.done_row = 1'b1;
    step();
    bus.done_row = 1'b0;
    chk("stray_done_row_busy", bus.busy, 0);
    step();
    chk("stray_done_row_launch", bus.begin_mult, 0);
    chk("stray_done_row_res_valid", bus.res_valid, 0);

    // main pass, 400-cycle multiplier, stray start during row 2
    vals = '{16'd5, 16'd9, 16'd3, 16'd9, 16'd0, 16'd1, 16'd2, 16'd8, 16'd7, 16'd6};
    ovfs = '{default: 1'b0};
    pulse_start();
    run_pass(400, NUM_ROWS, 1'b1);
    chk("main_class_out", bus.class_out, 1);
    chk("main_max_value", bus.max_value, 16'd9);
    chk("main_ovf_any", bus.ovf_any, 0);
    step();
    chk("main_busy_after", bus.busy, 0);
    chk("main_done_width", bus.done, 0);
    chk("main_class_held", bus.class_out, 1);
    chk("main_bm_count", bm_cnt, 10);
    chk("main_rv_count", rv_cnt, 10);
    chk("main_done_count", done_cnt, 1);
    chk("main_bm_wide", wide_err, 0);
    chk("main_sel_stable", sel_err, 0);

    // overflow on row 4 with a small raw value; rows 2 and 7 tie for the raw maximum
    vals = '{16'h0020, 16'h0050, 16'h0100, 16'h0030, 16'h0010,
             16'h00FF, 16'h0001, 16'h0100, 16'h0002, 16'h0003};
    ovfs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pulse_start();
    run_pass(3, NUM_ROWS, 1'b0);
`ifdef MULT_SAT_EN
    chk("ovf_class_out", bus.class_out, 4);
    chk("ovf_max_value", bus.max_value, 16'hFFFF);
`else
    chk("ovf_class_out", bus.class_out, 2);
    chk("ovf_max_value", bus.max_value, 16'h0100);
`endif
    chk("ovf_ovf_any", bus.ovf_any, 1);
    step();

    // abort in the WAIT of row 3
    vals = '{16'd5, 16'd9, 16'd3, 16'd9, 16'd0, 16'd1, 16'd2, 16'd8, 16'd7, 16'd6};
    ovfs = '{default: 1'b0};
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
    pulse_start();
    run_pass(4, 3, 1'b0);
    step();
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_no_launch", bus.begin_mult, 0);
    repeat (5) step();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_rv_count", rv_cnt, 3);
    chk("abort_bm_count", bm_cnt, 4);
    chk("abort_class_held", bus.class_out, 1);
    chk("abort_max_held", bus.max_value, 16'd9);

    // start and abort together in IDLE: start wins, full pass from row 0
    bus.abort = 1'b1;
    pulse_start();
    bus.abort = 1'b0;
    run_pass(2, NUM_ROWS, 1'b0);
    chk("rerun_class_out", bus.class_out, 1);
    chk("rerun_max_value", bus.max_value, 16'd9);
    step();
    chk("rerun_busy_after", bus.busy, 0);

    // asynchronous reset in the WAIT of row 2
    pulse_start();
    run_pass(2, 2, 1'b0);
    step();
    chk("pre_rst_row_select", bus.row_select, 2);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_row_select", bus.row_select, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_res_data", bus.res_data, 0);
    chk("mid_rst_res_row", bus.res_row, 0);
    chk("mid_rst_class_out", bus.class_out, 0);
    chk("mid_rst_max_value", bus.max_value, 0);
    chk("mid_rst_ovf_any", bus.ovf_any, 0);
    step();
    n_rst = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_row_sequencer.md
# mult_row_sequencer

Controller that sequences the row multiplier across all output neurons of a fully-connected layer. On `start` it launches one multiplier row per output (row_select 0..NUM_ROWS-1), waits for each `done_row`, and captures each 16-bit row result and its overflow bit. It streams the results out and tracks a running argmax. It sits between the top-level classifier FSM and the multiplier, and is the only driver of the multiplier's `row_select`/`begin_mult`.

## Interface
- NUM_ROWS, 10, number of output rows per pass (1..16)
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- start  input  1  begin a layer pass; sampled only in IDLE
- abort  input  1  synchronous cancel; return to IDLE, no `done`
- done_row  input  1  multiplier row-complete pulse
- row_result  input  16  multiplier accumulated row value
- row_overflow  input  1  multiplier overflow bit for that row
- row_select  output  4  row index to multiplier; stable from LAUNCH through WAIT
- begin_mult  output  1  one-cycle launch pulse to multiplier
- busy  output  1  high in every state except IDLE
- res_valid  output  1  one-cycle pulse: res_row/res_data/res_ovf valid
- res_row  output  4  row index of streamed result
- res_data  output  16  captured (optionally saturated) row value
- res_ovf  output  1  captured overflow bit
- done  output  1  one-cycle pulse at end of pass
- class_out  output  4  argmax row index, held until next start
- max_value  output  16  value at class_out, held until next start
- ovf_any  output  1  sticky OR of all row overflows this pass

## Operation
- States: IDLE, LAUNCH, WAIT, CAPTURE, FINISH.
- IDLE: `start`=1 -> clear row counter, max_value, class_out, ovf_any -> LAUNCH.
- LAUNCH: begin_mult=1 for exactly this cycle; row_select=counter -> WAIT.
- WAIT: hold row_select. On `done_row`=1, register row_result/row_overflow -> CAPTURE. There is no timeout.
- CAPTURE: res_valid=1 with registered data. Update argmax if row==0 or res_data > max_value (strict greater; ties keep the lower index). ovf_any |= res_ovf. If counter==NUM_ROWS-1 -> FINISH, else counter+1 -> LAUNCH.
- FINISH: done=1 one cycle -> IDLE; class_out/max_value/ovf_any remain held.
- `start` outside IDLE is ignored. `done_row` outside WAIT is ignored.
- `abort` (any non-IDLE state) -> IDLE next cycle. No res_valid/done is generated. Held outputs keep partial values. If abort and start are both high in IDLE, start wins.
- Comparison is unsigned 16-bit.

## Timing
- Reset: state IDLE, row_select=0, begin_mult=0, busy=0, res_valid=0, res_row=0, res_data=0, res_ovf=0, done=0, class_out=0, max_value=0, ovf_any=0.
- start(cycle 0) -> begin_mult at cycle 1.
- done_row at cycle N -> res_valid at N+1 -> next begin_mult at N+2.
- Overhead per row: 3 cycles beyond the multiplier latency. Last res_valid at N+1 -> done at N+2.
- class_out/max_value are updated on the clock edge ending CAPTURE, so they are final when done is high.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.

## Configuration
- MULT_SAT_EN defined:
  - A row with row_overflow=1 is captured as res_data=16'hFFFF and compared as such.
  - res_ovf still reports 1.
- MULT_SAT_EN undefined:
  - res_data = raw row_result (wrapped low 16 bits).
  - The comparison uses the raw value.

## Test plan
- Reset, then start with rows returning 5,9,3,9,0,1,2,8,7,6 -> 10 res_valid pulses in order, class_out=1, max_value=9, ovf_any=0, single done pulse.
- Check begin_mult count = 10, each 1 cycle wide, and row_select constant through each WAIT. done_row 400 cycles after each launch -> next begin_mult exactly 2 cycles after done_row.
- Row 4 returns row_result=16'h0010 with row_overflow=1, others ≤16'h0100:
  - With MULT_SAT_EN: class_out=4, max_value=FFFF, ovf_any=1.
  - Without: class_out = index of largest raw value, ovf_any=1.
- abort asserted in WAIT of row 3 -> IDLE next cycle, busy=0, no done. A following start runs all 10 rows from row 0.
- Stray done_row in IDLE and start pulses mid-pass -> no state change, no extra begin_mult. n_rst low mid-pass -> all outputs at reset values immediately.
